audio_mix_engine: RTL and testbench
===================================

Name: audio_mix_engine

Overview:
- Parametrised N-channel audio mixer that produces the AC97 PCM left/right slots (slot3/slot4) from per-channel unsigned level codes.
- Supports per-channel left/right routing, per-side master volume shift and signed saturation.
- Sequential engine: snapshots inputs on each frame strobe and accumulates one channel per bit clock.
- Results are presented frame-aligned, so slot data never changes mid-frame. Sits between the sound-channel generators and the AC-link serialiser.

Parameters:
NUM_CH, 4, number of input channels (1..64)
LEVEL_W, 4, width of each channel level code (unsigned, midpoint 2^(LEVEL_W-1))
OUT_W, 20, output slot width (two's complement)
VOL_W, 4, width of master volume shift amount

Ports:
ac97_bitclk  in  1  AC97 bit clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ac97_strobe  in  1  frame strobe, one cycle per 256-cycle frame
mix_enable  in  1  0 = produce silence (all-zero samples)
ch_level  in  NUM_CH*LEVEL_W  channel levels; channel k at [k*LEVEL_W +: LEVEL_W]
ch_left_en  in  NUM_CH  bit k routes channel k to left
ch_right_en  in  NUM_CH  bit k routes channel k to right
vol_left  in  VOL_W  left master left-shift amount
vol_right  in  VOL_W  right master left-shift amount
ac97_out_slot3  out  OUT_W  left sample
ac97_out_slot4  out  OUT_W  right sample
sample_valid  out  1  one-cycle pulse when slot outputs update
clip_left  out  1  left sample currently output was saturated
clip_right  out  1  right sample currently output was saturated
busy  out  1  accumulation in progress

Behaviour:
- Reset (async, reset_n=0): slots=0, sample_valid=0, clip_*=0, busy=0, pending regs=0, state=IDLE. Reset mid-accumulation discards the partial sum.
- States: IDLE, ACCUM, SCALE.
- Any state, ac97_strobe=1:
  - Copy pending_l/r and pending clip flags to slot3/slot4/clip_*; assert sample_valid that cycle.
  - Snapshot ch_level, ch_*_en, vol_*, mix_enable into shadow regs; clear acc_l/acc_r; idx=0.
  - Go to ACCUM; busy=1.
- ACCUM, one channel per cycle:
  - s = level[idx] - 2^(LEVEL_W-1), signed, range -8..+7 for LEVEL_W=4.
  - acc_l += s if left_en[idx]; acc_r += s if right_en[idx].
  - At idx==NUM_CH-1 go to SCALE, else idx++.
- SCALE, one cycle:
  - v = acc << vol, computed at full width ACC_W + 2^VOL_W - 1, where ACC_W = LEVEL_W + clog2(NUM_CH) + 1.
  - Saturate to OUT_W signed: max 2^(OUT_W-1)-1, min -2^(OUT_W-1). Clip flag set if saturated.
  - If shadow mix_enable=0: pending=0 and clip=0.
  - Write pending_l/r and clip flags; go to IDLE; busy=0.
- Latency: pending is valid NUM_CH+1 cycles after the strobe. Slots present the mix of the inputs snapshotted at strobe n starting at strobe n+1. This is one-frame latency.
- Outputs change only on the strobe cycle and are stable for the whole frame.
- Input changes between strobes have no effect until the next strobe.
- Strobe arriving while busy: pending is not updated by the aborted computation. The outputs take the last completed pending values, and accumulation restarts from the new snapshot. No X and no partial sums ever reach the outputs.
- Simultaneous reset and strobe: reset wins.
- Constraint: NUM_CH+2 <= 256, so normal frames always complete.
- A channel with both enables clear contributes nothing. With all enables clear, the result is 0 regardless of levels.

Test Plan:
- Reset asserted mid-ACCUM with levels at 15 -> slot3=slot4=0, clip=0, busy=0 immediately; first post-reset strobe outputs 0x00000.
- NUM_CH=4, all levels 15, all enables 1, vol=0, two strobes -> slot3=slot4=0x0001C (+28), sample_valid pulses on each strobe, clip=0.
- All levels 0, left_en=0xF, right_en=0x0, vol=0 -> slot3=0xFFFE0 (-32), slot4=0x00000.
- Saturation:
  - All levels 15, vol_left=15 -> 28<<15 overflows, so slot3=0x7FFFF and clip_left=1.
  - All levels 0, vol_right=15 -> slot4=0x80000, clip_right=1.
  - vol=4 with levels 15 -> 0x001C0, no clip.
- Strobe pulses 3 cycles apart (aborted compute), then a normal 256-cycle strobe -> second strobe outputs the prior completed value unchanged; third strobe outputs the restarted result. Inputs toggled mid-frame never alter the slots between strobes.
- mix_enable=0 with levels 15 -> slot3=slot4=0 at the next strobe; re-enable -> 0x0001C one frame later.

Source files
------------

// File: rtl/audio_mix_engine.sv
// N-channel AC97 PCM mixer: snapshots channel levels on each frame strobe, accumulates
// one channel per bit clock, scales/saturates, and presents the result one frame later.
module audio_mix_engine #(
  parameter int NUM_CH  = 4,
  parameter int LEVEL_W = 4,
  parameter int OUT_W   = 20,
  parameter int VOL_W   = 4
) (
  input  logic                        ac97_bitclk,
  input  logic                        reset_n,
  input  logic                        ac97_strobe,
  input  logic                        mix_enable,
  input  logic [NUM_CH*LEVEL_W-1:0]   ch_level,
  input  logic [NUM_CH-1:0]           ch_left_en,
  input  logic [NUM_CH-1:0]           ch_right_en,
  input  logic [VOL_W-1:0]            vol_left,
  input  logic [VOL_W-1:0]            vol_right,
  output logic [OUT_W-1:0]            ac97_out_slot3,
  output logic [OUT_W-1:0]            ac97_out_slot4,
  output logic                        sample_valid,
  output logic                        clip_left,
  output logic                        clip_right,
  output logic                        busy
);

  localparam int ACC_W  = LEVEL_W + $clog2(NUM_CH) + 1;
  localparam int FULL_W = ACC_W + (1 << VOL_W) - 1;
  localparam int EXT_W  = (FULL_W > OUT_W) ? FULL_W : OUT_W;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [ACC_W-1:0]        MID      = ACC_W'(1) << (LEVEL_W - 1);
  localparam logic [OUT_W-1:0]        OMAX     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OMIN     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SMAX     = EXT_W'(OMAX);
  localparam logic signed [EXT_W-1:0] SMIN     = ~SMAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                      r_state, w_next;
  logic [NUM_CH*LEVEL_W-1:0]   r_lvl;
  logic [NUM_CH-1:0]           r_len, r_ren;
  logic [VOL_W-1:0]            r_vol_l, r_vol_r;
  logic                        r_men;
  logic [IDX_W-1:0]            r_idx;
  logic signed [ACC_W-1:0]     r_acc_l, r_acc_r;
  logic [OUT_W-1:0]            r_pend_l, r_pend_r, r_slot_l, r_slot_r;
  logic                        r_pclip_l, r_pclip_r, r_clip_l, r_clip_r;
  logic                        r_valid;

  logic [LEVEL_W-1:0]          w_lvl;
  logic signed [ACC_W-1:0]     w_s;
  logic signed [EXT_W-1:0]     w_vl, w_vr;
  logic [OUT_W:0]              w_sat_l, w_sat_r;

  // Returns {clip, saturated sample}
  function automatic logic [OUT_W:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SMAX)      sat = {1'b1, OMAX};
    else if (v < SMIN) sat = {1'b1, OMIN};
    else               sat = {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    w_lvl   = r_lvl[r_idx*LEVEL_W +: LEVEL_W];
    w_s     = ACC_W'(w_lvl) - MID;
    w_vl    = EXT_W'(r_acc_l) <<< r_vol_l;
    w_vr    = EXT_W'(r_acc_r) <<< r_vol_r;
    w_sat_l = sat(w_vl);
    w_sat_r = sat(w_vr);
  end

  always_ff @(posedge ac97_bitclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ac97_strobe) begin
      w_next = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (r_idx == LAST_IDX) w_next = SCALE;
        SCALE:   w_next = IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // A strobe overrides SCALE too, so an aborted frame never reaches pending.
  always_ff @(posedge ac97_bitclk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl     <= '0;
      r_len     <= '0;
      r_ren     <= '0;
      r_vol_l   <= '0;
      r_vol_r   <= '0;
      r_men     <= 1'b0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_pend_l  <= '0;
      r_pend_r  <= '0;
      r_pclip_l <= 1'b0;
      r_pclip_r <= 1'b0;
      r_slot_l  <= '0;
      r_slot_r  <= '0;
      r_clip_l  <= 1'b0;
      r_clip_r  <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= ac97_strobe;
      if (ac97_strobe) begin
        r_slot_l <= r_pend_l;
        r_slot_r <= r_pend_r;
        r_clip_l <= r_pclip_l;
        r_clip_r <= r_pclip_r;
        r_lvl    <= ch_level;
        r_len    <= ch_left_en;
        r_ren    <= ch_right_en;
        r_vol_l  <= vol_left;
        r_vol_r  <= vol_right;
        r_men    <= mix_enable;
        r_acc_l  <= '0;
        r_acc_r  <= '0;
        r_idx    <= '0;
      end else begin
        case (r_state)
          ACCUM: begin
            if (r_len[r_idx]) r_acc_l <= r_acc_l + w_s;
            if (r_ren[r_idx]) r_acc_r <= r_acc_r + w_s;
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end
          SCALE: begin
            if (r_men) begin
              r_pend_l  <= w_sat_l[OUT_W-1:0];
              r_pend_r  <= w_sat_r[OUT_W-1:0];
              r_pclip_l <= w_sat_l[OUT_W];
              r_pclip_r <= w_sat_r[OUT_W];
            end else begin
              r_pend_l  <= '0;
              r_pend_r  <= '0;
              r_pclip_l <= 1'b0;
              r_pclip_r <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ac97_out_slot3 = r_slot_l;
  assign ac97_out_slot4 = r_slot_r;
  assign sample_valid   = r_valid;
  assign clip_left      = r_clip_l;
  assign clip_right     = r_clip_r;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_audio_mix_engine.sv
// Directed bench for audio_mix_engine (NUM_CH=4, LEVEL_W=4, OUT_W=20, VOL_W=4).
module tb_audio_mix_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic        men;
  logic [15:0] lvl;
  logic [3:0]  len, ren, vl, vr;
  logic [19:0] s3, s4;
  logic        valid, cl, cr, bsy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_mix_engine #(.NUM_CH(4), .LEVEL_W(4), .OUT_W(20), .VOL_W(4)) dut (
    .ac97_bitclk    (clk),
    .reset_n        (rst_n),
    .ac97_strobe    (strobe),
    .mix_enable     (men),
    .ch_level       (lvl),
    .ch_left_en     (len),
    .ch_right_en    (ren),
    .vol_left       (vl),
    .vol_right      (vr),
    .ac97_out_slot3 (s3),
    .ac97_out_slot4 (s4),
    .sample_valid   (valid),
    .clip_left      (cl),
    .clip_right     (cr),
    .busy           (bsy)
  );

  typedef struct packed {
    logic [15:0] lvl;
    logic [3:0]  len, ren, vl, vr;
    logic        men;
    logic [19:0] e3, e4;
    logic        c3, c4;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic strobe_now();
    @(negedge clk);
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] l, input logic [3:0] le, input logic [3:0] re,
                        input logic [3:0] vle, input logic [3:0] vre, input logic m);
    lvl = l; len = le; ren = re; vl = vle; vr = vre; men = m;
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 4'hF, 4'hF, 4'd0,  4'd0,  1'b1, 20'h0001C, 20'h0001C, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 4'hF, 4'h0, 4'd0,  4'd0,  1'b1, 20'hFFFE0, 20'h00000, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 4'hF, 4'hF, 4'd15, 4'd0,  1'b1, 20'h7FFFF, 20'h0001C, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 4'h0, 4'hF, 4'd0,  4'd15, 1'b1, 20'h00000, 20'h80000, 1'b0, 1'b1};
    tbl[4] = '{16'hFFFF, 4'hF, 4'hF, 4'd4,  4'd4,  1'b1, 20'h001C0, 20'h001C0, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 4'hF, 4'hF, 4'd0,  4'd0,  1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
    tbl[6] = '{16'hC38A, 4'h5, 4'hA, 4'd1,  4'd2,  1'b1, 20'hFFFFA, 20'h00010, 1'b0, 1'b0};
    tbl[7] = '{16'h0000, 4'h0, 4'h0, 4'd15, 4'd15, 1'b1, 20'h00000, 20'h00000, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 4'hF, 4'h0, 4'd14, 4'd0,  1'b1, 20'h80000, 20'h00000, 1'b0, 1'b0};
    tbl[9] = '{16'hFFFF, 4'h0, 4'hF, 4'd0,  4'd14, 1'b1, 20'h00000, 20'h70000, 1'b0, 1'b0};

    rst_n  = 1'b0;
    strobe = 1'b0;
    set_in(16'h0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0);
    cycles(3);
    chk("rst_slot3", 32'(s3), 32'h0);
    chk("rst_slot4", 32'(s4), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_clip", 32'({cl, cr}), 32'h0);
    chk("rst_busy", 32'(bsy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: busy spans NUM_CH accumulate cycles plus the scale cycle
    set_in(16'hFFFF, 4'hF, 4'hF, 4'd0, 4'd0, 1'b1);
    strobe_now();
    chk("busy_after_strobe", 32'(bsy), 32'h1);
    cycles(4);
    chk("busy_in_scale", 32'(bsy), 32'h1);
    cycles(1);
    chk("busy_done", 32'(bsy), 32'h0);
    cycles(250);
    strobe_now();
    chk("first_result_slot3", 32'(s3), 32'h0001C);
    chk("first_result_valid", 32'(valid), 32'h1);
    cycles(2);
    rst_n = 1'b0;
    #1;
    chk("midreset_slot3", 32'(s3), 32'h0);
    chk("midreset_slot4", 32'(s4), 32'h0);
    chk("midreset_busy", 32'(bsy), 32'h0);
    chk("midreset_clip", 32'({cl, cr}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(20);
    strobe_now();
    chk("post_reset_slot3", 32'(s3), 32'h0);
    chk("post_reset_slot4", 32'(s4), 32'h0);
    cycles(255);

    // Aborted compute: strobes 3 cycles apart, then a full frame
    set_in(16'hFFFF, 4'hF, 4'hF, 4'd0, 4'd0, 1'b1);
    strobe_now();
    cycles(255);
    set_in(16'h0000, 4'hF, 4'hF, 4'd0, 4'd0, 1'b1);
    strobe_now();
    chk("abort_s1_slot3", 32'(s3), 32'h0001C);
    cycles(2);
    set_in(16'hFFFF, 4'hF, 4'hF, 4'd4, 4'd4, 1'b1);
    strobe_now();
    chk("abort_s2_slot3", 32'(s3), 32'h0001C);
    chk("abort_s2_slot4", 32'(s4), 32'h0001C);
    chk("abort_s2_busy", 32'(bsy), 32'h1);
    cycles(100);
    set_in(16'h1234, 4'h3, 4'h6, 4'd9, 4'd2, 1'b0);
    cycles(50);
    chk("midframe_stable_slot3", 32'(s3), 32'h0001C);
    chk("midframe_stable_valid", 32'(valid), 32'h0);
    cycles(105);
    strobe_now();
    chk("abort_s3_slot3", 32'(s3), 32'h001C0);
    chk("abort_s3_slot4", 32'(s4), 32'h001C0);
    cycles(255);

    // Mix disable then re-enable
    set_in(16'hFFFF, 4'hF, 4'hF, 4'd0, 4'd0, 1'b0);
    strobe_now();
    cycles(255);
    men = 1'b1;
    strobe_now();
    chk("mute_slot3", 32'(s3), 32'h0);
    chk("mute_slot4", 32'(s4), 32'h0);
    cycles(255);
    strobe_now();
    chk("unmute_slot3", 32'(s3), 32'h0001C);
    chk("unmute_slot4", 32'(s4), 32'h0001C);
    cycles(255);

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].lvl, tbl[i].len, tbl[i].ren, tbl[i].vl, tbl[i].vr, tbl[i].men);
      strobe_now();
      cycles(10);
      set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      cycles(245);
      strobe_now();
      chk($sformatf("vec%0d_slot3", i), 32'(s3), 32'(tbl[i].e3));
      chk($sformatf("vec%0d_slot4", i), 32'(s4), 32'(tbl[i].e4));
      chk($sformatf("vec%0d_clipl", i), 32'(cl), 32'(tbl[i].c3));
      chk($sformatf("vec%0d_clipr", i), 32'(cr), 32'(tbl[i].c4));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'h1);
      cycles(1);
      chk($sformatf("vec%0d_valid_low", i), 32'(valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
